// File: rtl/debounce_multi.sv
// Multi-channel input conditioner: per channel synchroniser, stability-qualified
// debounced level, one-cycle rise/fall pulses and a one-shot long-press pulse.
module debounce_multi #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CNT  = 16,
  parameter int unsigned LONG_CNT    = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_en,
  input  logic [N_CH-1:0] signal,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press
);

  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CNT);
  localparam bit               LONG_ON   = (LONG_CNT != 0);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_multi: SYNC_STAGES must be at least 2");
  end
  if (STABLE_CNT < 1) begin : g_bad_stable
    $error("debounce_multi: STABLE_CNT must be at least 1");
  end
  if ((64'(1) << CNT_W) <= 64'(STABLE_CNT) || (64'(1) << CNT_W) <= 64'(LONG_CNT)) begin : g_bad_width
    $error("debounce_multi: CNT_W too narrow for STABLE_CNT/LONG_CNT");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       stab_q;
    logic [CNT_W-1:0]       hold_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   long_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q  <= '0;
        stab_q  <= '0;
        hold_q  <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], signal[i]};
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        long_q <= 1'b0;
        if (sample_en) begin
          if (s == level_q) begin
            stab_q <= '0;
          end else if (stab_q == STAB_LAST) begin
            level_q <= s;
            stab_q  <= '0;
            rise_q  <= s;
            fall_q  <= ~s;
          end else begin
            stab_q <= stab_q + 1'b1;
          end
          // hold uses the pre-update level, so counting begins the sample after rise
          if (!level_q) begin
            hold_q <= '0;
          end else if (LONG_ON && (hold_q < LONG_MAX)) begin
            hold_q <= hold_q + 1'b1;
            if (hold_q == LONG_MAX - 1'b1) long_q <= 1'b1;
          end
        end
      end
    end

    assign level[i]      = level_q;
    assign rise[i]       = rise_q;
    assign fall[i]       = fall_q;
    assign long_press[i] = long_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed table, corner sequences and
// randomized stimulus compared against a sample-index based reference model.
module tb_debounce_multi;
  localparam int unsigned N  = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned SC = 4;
  localparam int unsigned LC = 10;
  localparam int unsigned CW = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sample_en = 1'b0;
  logic [N-1:0] signal = '0;
  logic [N-1:0] level, rise, fall, long_press;

  debounce_multi #(
    .N_CH(N), .SYNC_STAGES(SS), .STABLE_CNT(SC), .LONG_CNT(LC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .signal(signal),
    .level(level), .rise(rise), .fall(fall), .long_press(long_press)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: level changes once SC consecutive enabled samples of the
  // synchronised input disagree; long_press fires LC samples after the rise.
  logic [N-1:0] m_level, m_rise, m_fall, m_lp;
  int           n;
  int           last_agree [N];
  int           rise_n [N];
  logic [N-1:0] hist [$];

  task automatic model_reset();
    m_level = '0; m_rise = '0; m_fall = '0; m_lp = '0;
    n = 0;
    for (int c = 0; c < N; c++) begin
      last_agree[c] = 0;
      rise_n[c] = 0;
    end
    hist.delete();
    for (int k = 0; k < SS; k++) hist.push_back('0);
  endtask

  task automatic model_edge(input logic r, input logic en, input logic [N-1:0] sg);
    logic [N-1:0] sv;
    logic old;
    if (!r) begin
      model_reset();
      return;
    end
    hist.push_back(sg);
    sv = hist[hist.size() - 1 - SS];
    void'(hist.pop_front());
    m_rise = '0; m_fall = '0; m_lp = '0;
    if (en) begin
      n++;
      for (int c = 0; c < N; c++) begin
        old = m_level[c];
        if (old && (n - rise_n[c] == LC)) m_lp[c] = 1'b1;
        if (sv[c] == old) begin
          last_agree[c] = n;
        end else if (n - last_agree[c] == SC) begin
          m_level[c] = sv[c];
          last_agree[c] = n;
          if (sv[c]) begin
            m_rise[c] = 1'b1;
            rise_n[c] = n;
          end else begin
            m_fall[c] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic [N-1:0] sg);
    @(negedge clk);
    rst = r; sample_en = en; signal = sg;
    @(posedge clk);
    model_edge(r, en, sg);
    #1;
    check("model", {16'h0, level, rise, fall, long_press}, {16'h0, m_level, m_rise, m_fall, m_lp});
  endtask

  typedef struct {
    logic [N-1:0] sig;
    logic [N-1:0] lvl;
    logic [N-1:0] rs;
    logic [N-1:0] fl;
    logic [N-1:0] lp;
  } vec_t;
  vec_t tbl [14];

  int   bad, rise_cnt, fall_cnt, lp_cnt, rise_at, lp_at, first_at;
  logic [N-1:0] first_val, cur;
  logic en_r;

  initial begin
    // clean press/release on ch0: level shows on the 6th edge counted from the sampling edge
    for (int i = 0; i < 14; i++) begin
      tbl[i].sig = (i < 7) ? 4'b0001 : 4'b0000;
      tbl[i].lvl = (i >= 5 && i <= 11) ? 4'b0001 : 4'b0000;
      tbl[i].rs  = (i == 5) ? 4'b0001 : 4'b0000;
      tbl[i].fl  = (i == 12) ? 4'b0001 : 4'b0000;
      tbl[i].lp  = 4'b0000;
    end

    model_reset();
    step(1'b0, 1'b1, 4'b1111);
    check("reset_state", {level, rise, fall, long_press}, 32'h0);
    step(1'b0, 1'b1, 4'b0000);
    repeat (3) step(1'b1, 1'b1, 4'b0000);

    // 1. table
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b1, tbl[i].sig);
      check("tbl_level", level, tbl[i].lvl);
      check("tbl_rise", rise, tbl[i].rs);
      check("tbl_fall", fall, tbl[i].fl);
      check("tbl_long", long_press, tbl[i].lp);
    end

    // 2. bounce on ch1 then an accepted 4-cycle high
    bad = 0;
    repeat (3) begin step(1'b1, 1'b1, 4'b0010); bad |= int'(level[1] | rise[1] | fall[1]); end
    repeat (2) begin step(1'b1, 1'b1, 4'b0000); bad |= int'(level[1] | rise[1] | fall[1]); end
    repeat (2) begin step(1'b1, 1'b1, 4'b0010); bad |= int'(level[1] | rise[1] | fall[1]); end
    repeat (2) begin step(1'b1, 1'b1, 4'b0000); bad |= int'(level[1] | rise[1] | fall[1]); end
    repeat (1) begin step(1'b1, 1'b1, 4'b0010); bad |= int'(level[1] | rise[1] | fall[1]); end
    repeat (6) begin step(1'b1, 1'b1, 4'b0000); bad |= int'(level[1] | rise[1] | fall[1]); end
    check("bounce_quiet", bad, 0);
    rise_cnt = 0; fall_cnt = 0;
    repeat (4) begin step(1'b1, 1'b1, 4'b0010); rise_cnt += int'(rise[1]); fall_cnt += int'(fall[1]); end
    repeat (8) begin step(1'b1, 1'b1, 4'b0000); rise_cnt += int'(rise[1]); fall_cnt += int'(fall[1]); end
    check("bounce_accept_rise", rise_cnt, 1);
    check("bounce_accept_fall", fall_cnt, 1);

    // 3. long press on ch2, twice
    for (int pass = 0; pass < 2; pass++) begin
      rise_cnt = 0; lp_cnt = 0; rise_at = -1; lp_at = -1;
      for (int c = 0; c < 30; c++) begin
        step(1'b1, 1'b1, 4'b0100);
        if (rise[2]) begin rise_cnt++; rise_at = c; end
        if (long_press[2]) begin lp_cnt++; lp_at = c; end
      end
      for (int c = 0; c < 10; c++) begin
        step(1'b1, 1'b1, 4'b0000);
        lp_cnt += int'(long_press[2]);
      end
      check("long_rise_count", rise_cnt, 1);
      check("long_pulse_count", lp_cnt, 1);
      check("long_rise_cycle", rise_at, 5);
      check("long_delay", lp_at - rise_at, LC);
    end

    // 4. simultaneous press on all channels, then release of 3 and 1
    first_at = -1; first_val = '0; rise_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b1, 4'b1111);
      if (rise != 0) begin
        rise_cnt++;
        if (first_at < 0) begin first_at = c; first_val = rise; end
      end
    end
    check("simul_rise_val", first_val, 4'b1111);
    check("simul_rise_cycles", rise_cnt, 1);
    first_at = -1; first_val = '0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b1, 4'b0101);
      if (rise != 0) bad = 1;
      if (fall != 0 && first_at < 0) begin first_at = c; first_val = fall; end
    end
    check("simul_fall_val", first_val, 4'b1010);
    check("simul_no_rise", bad, 0);
    check("simul_level", level, 4'b0101);

    // 5. reset two samples into a stable high on ch0
    repeat (8) step(1'b1, 1'b1, 4'b0100);
    repeat (4) step(1'b1, 1'b1, 4'b0101);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check("async_reset", {level, rise, fall, long_press}, 32'h0);
    repeat (2) step(1'b0, 1'b1, 4'b0101);
    first_at = -1; first_val = '0;
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 1'b1, 4'b0101);
      if (rise != 0 && first_at < 0) begin first_at = c; first_val = rise; end
    end
    check("post_reset_rise_cycle", first_at, 5);
    check("post_reset_rise_val", first_val, 4'b0101);

    // 6. sample gating, one enabled sample in four
    repeat (10) step(1'b1, 1'b1, 4'b0000);
    bad = 0; rise_at = -1;
    for (int c = 0; c < 24; c++) begin
      en_r = ((c % 4) == 3);
      step(1'b1, en_r, 4'b0001);
      if (!en_r && (rise != 0 || fall != 0 || long_press != 0)) bad = 1;
      if (rise[0] && rise_at < 0) rise_at = c;
    end
    check("gated_rise_cycle", rise_at, 15);
    check("gated_no_pulse", bad, 0);
    check("gated_level", level, 4'b0001);

    // random: fast-toggling then slow-toggling inputs, occasional reset
    cur = '0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 1500; k++) begin
        for (int c = 0; c < N; c++)
          if ($urandom_range(0, (ph == 0) ? 5 : 29) == 0) cur[c] = ~cur[c];
        en_r = (ph == 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) != 0);
        step(($urandom_range(0, 299) != 0), en_r, cur);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-button synchroniser + counter debouncer.
- Each channel synchronises a raw asynchronous input and accepts a new level only after it has been stable for a programmable number of sample ticks.
- Each channel also emits one-cycle press/release pulses and a one-shot long-press pulse.
- Sits between the raw input pads and the control FSMs; one instance serves all push-buttons and sensors.

Parameters:
- N_CH, 4, number of independent channels.
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- STABLE_CNT, 16, consecutive differing samples required to accept a new level (>=1).
- LONG_CNT, 1000, samples with level held at 1 before long_press fires; 0 disables long_press.
- CNT_W, 16, width of the stability and hold counters; must hold max(STABLE_CNT, LONG_CNT).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- sample_en  input  1  sample tick; counters advance only when 1.
- signal  input  N_CH  raw asynchronous inputs.
- level  output  N_CH  debounced level.
- rise  output  N_CH  one-cycle pulse on a debounced 0->1 transition.
- fall  output  N_CH  one-cycle pulse on a debounced 1->0 transition.
- long_press  output  N_CH  one-cycle pulse when level has been held at 1 for LONG_CNT samples.

Behaviour:
- Reset (rst=0, asynchronous): sync chains, counters, level, rise, fall and long_press all go to 0. Outputs are registered and stay 0 until rst=1 and the conditions below are met.
- Synchroniser:
  - signal[i] passes through SYNC_STAGES flops every clk, regardless of sample_en.
  - s[i] is the last stage.
- Stability counter stab[i], evaluated when sample_en=1:
  - s[i]==level[i]: stab <= 0.
  - s[i]!=level[i] and stab < STABLE_CNT-1: stab <= stab+1.
  - s[i]!=level[i] and stab == STABLE_CNT-1: level[i] <= s[i], stab <= 0, and rise[i] or fall[i] <= 1 in that same edge.
  - With STABLE_CNT=1, level follows s on the next sampled edge.
- sample_en=0: stab, hold and level keep their values; rise, fall and long_press are 0.
- Edge pulses: rise and fall are high for exactly one clk, in the cycle level first shows its new value. They are never both high on one channel.
- Latency, with sample_en tied to 1: a clean input step appears on level SYNC_STAGES + STABLE_CNT clk edges after the first edge that samples the new value into stage 1.
- Bounce: any return of s to level before the count completes clears stab, so no output change occurs.
- Hold counter hold[i], evaluated when sample_en=1:
  - Cleared whenever level[i]==0.
  - While level[i]==1 and hold < LONG_CNT: hold <= hold+1. When hold reaches LONG_CNT, long_press[i] pulses for one clk.
  - hold then saturates at LONG_CNT, so no further long_press occurs until level returns to 0 and rises again.
  - Counting starts on the sample after the rise pulse, so long_press fires LONG_CNT samples after the rise.
- Channel independence: channels share no state, so simultaneous events on any subset of channels are handled independently in the same cycle.
- Reset mid-operation: in-progress counts are discarded. After release, a held-high input is re-qualified from 0 and produces a fresh rise.
- Arithmetic: counters are unsigned CNT_W bits and never wrap. Comparisons use the parameter constants.

Test Plan:
Common configuration: N_CH=4, SYNC_STAGES=2, STABLE_CNT=4, LONG_CNT=10, sample_en=1 unless stated.
1. Clean press: signal[0] 0->1 held.
   - level[0]=1 and rise[0]=1 for exactly one cycle, 6 edges after the first sampling edge.
   - Other channels stay 0.
   - Release produces fall[0] 6 edges after release.
2. Bounce: signal[1] toggles with high periods of 3, 2 and 1 cycles, then returns to 0.
   - level[1], rise[1] and fall[1] stay 0 throughout.
   - A subsequent 4-cycle-stable high is accepted.
3. Long press: signal[2]=1 held for 30 cycles.
   - rise[2] pulses once; long_press[2] pulses exactly once, 10 cycles after rise[2].
   - No repeat while held.
   - Release then re-press: rise and long_press recur.
4. Simultaneous: signal[3:0]=4'b1111 in the same cycle.
   - All four level bits and rise bits assert in the same cycle.
   - signal=4'b0101 afterwards gives fall on bits 3 and 1 only.
5. Reset mid-count: assert rst=0 two samples into a stable high on ch0, then release rst.
   - All outputs are 0 immediately, asynchronously.
   - level[0] rises 6 edges after release with a fresh rise[0].
6. Sample gating: sample_en=1 every 4th cycle, clean press on ch0.
   - level[0] rises only after 4 enabled samples.
   - Counters hold and pulses stay 0 while sample_en=0.
